// File: rtl/ad9781_spi_config.sv
// ad9781_spi_config: walks a register look-up table and writes each entry
// to an AD9781 DAC over 3-wire SPI (16-bit frame, MSB first, mode 0).
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         one-cycle request to rerun the table (IDLE/DONE only)
//   lut_index     table address, lut_data {addr[15:0], data[7:0]} back
//   spi_csn       chip select, active low
//   spi_sclk      serial clock, idle low
//   spi_sdio      serial data, changes on SCLK fall
//   busy          run in progress
//   config_done   last run completed, held until next run or reset
module ad9781_spi_config #(
  parameter int LUT_SIZE = 10,
  parameter int CLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        spi_csn,
  output logic        spi_sclk,
  output logic        spi_sdio,
  output logic        busy,
  output logic        config_done
);

  localparam int CW = $clog2(2 * CLK_DIV);

  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAPN = CW'(2 * CLK_DIV - 1);
  localparam logic [9:0]    LAST = 10'(LUT_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   sreg;
  logic          pending;

  // Write, one byte, 5-bit address, 8-bit data.
  logic [15:0] frame;
  logic        sentinel;

  assign frame    = {3'b000, lut_data[20:16], lut_data[7:0]};
  assign sentinel = &lut_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      spi_csn     <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_sdio    <= 1'b0;
      lut_index   <= '0;
      busy        <= 1'b0;
      config_done <= 1'b0;
      cnt         <= '0;
      bit_cnt     <= '0;
      sreg        <= '0;
      // Arms the automatic run on the first cycle out of reset.
      pending     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending || start) begin
            pending     <= 1'b0;
            lut_index   <= '0;
            busy        <= 1'b1;
            config_done <= 1'b0;
            state       <= LOAD;
          end
        end

        LOAD: begin
          if (sentinel) begin
            busy        <= 1'b0;
            config_done <= 1'b1;
            state       <= DONE;
          end else begin
            sreg     <= frame;
            spi_sdio <= frame[15];
            spi_csn  <= 1'b0;
            spi_sclk <= 1'b0;
            cnt      <= HALF;
            state    <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (cnt == '0) begin
            cnt     <= HALF;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        // spi_sclk doubles as the half-bit phase flag.
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt <= HALF;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state <= CS_HOLD;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                sreg     <= {sreg[14:0], sreg[15]};
                spi_sdio <= sreg[14];
              end
            end
          end
        end

        CS_HOLD: begin
          if (cnt == '0) begin
            spi_csn  <= 1'b1;
            spi_sdio <= 1'b0;
            cnt      <= GAPN;
            state    <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (lut_index == LAST) begin
            busy        <= 1'b0;
            config_done <= 1'b1;
            state       <= DONE;
          end else begin
            lut_index <= lut_index + 10'd1;
            state     <= LOAD;
          end
        end

        DONE: begin
          if (start) begin
            lut_index   <= '0;
            busy        <= 1'b1;
            config_done <= 1'b0;
            state       <= LOAD;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9781_spi_config.sv
// tb_ad9781_spi_config: random-table runs of ad9781_spi_config checked
// against a frame-level model of the configuration sequence.
module tb_ad9781_spi_config;

  localparam int LUT_SIZE = 10;
  localparam int CLK_DIV  = 2;
  localparam int ENTRY =
    1 + CLK_DIV + 32 * CLK_DIV + CLK_DIV + 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  lut_index;
  logic [23:0] lut_data;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_sdio;
  logic        busy;
  logic        config_done;

  logic [23:0] lut [0:1023];

  assign lut_data = lut[lut_index];

  always #5 clk = ~clk;

  ad9781_spi_config #(
    .LUT_SIZE(LUT_SIZE),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lut_index  (lut_index),
    .lut_data   (lut_data),
    .spi_csn    (spi_csn),
    .spi_sclk   (spi_sclk),
    .spi_sdio   (spi_sdio),
    .busy       (busy),
    .config_done(config_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI slave: decode frames on rising SCLK while CSN is low.
  logic        p_csn  = 1'b1;
  logic        p_sclk = 1'b0;
  logic        p_sdio = 1'b0;
  logic [15:0] cur    = '0;
  int          cur_edges = 0;
  logic [15:0] frames [$];
  int          edges  [$];
  logic [15:0] last_frames [$];

  always @(negedge clk) begin
    if (!spi_csn && p_csn) begin
      cur       = '0;
      cur_edges = 0;
    end
    if (!spi_csn && spi_sclk && !p_sclk) begin
      check("sdio_stable", 32'(spi_sdio), 32'(p_sdio));
      cur = {cur[14:0], spi_sdio};
      cur_edges++;
    end
    if (spi_csn && !p_csn) begin
      frames.push_back(cur);
      edges.push_back(cur_edges);
    end
    p_csn  = spi_csn;
    p_sclk = spi_sclk;
    p_sdio = spi_sdio;
  end

  // Reference model: frames expected from the table, run length, stop index.
  logic [15:0] exp_frames [$];
  int          exp_cycles;
  int          exp_last;

  task automatic model_run();
    exp_frames.delete();
    exp_cycles = 0;
    exp_last   = 0;
    for (int i = 0; i < LUT_SIZE; i++) begin
      exp_last = i;
      if (lut[i] == 24'hFFFFFF) begin
        exp_cycles += 1;
        break;
      end
      exp_frames.push_back({3'b000, lut[i][20:16], lut[i][7:0]});
      exp_cycles += ENTRY;
    end
  endtask

  task automatic fill_table();
    for (int i = 0; i < 16; i++) begin
      lut[i] = 24'($urandom);
      if (lut[i] == 24'hFFFFFF) lut[i] = 24'h000000;
    end
    lut[2] = {16'h0C00, 8'h02};
    lut[9] = {16'h0500, 8'h5A};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done_clr", 32'(config_done), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  // Called on the first sample after a run has begun.
  task automatic run_and_check(input string tag, input bit inject);
    int busy_cyc = 0;
    bit pb       = 1'b1;
    bit seen     = 1'b0;
    bit inj      = 1'b0;
    model_run();
    for (int k = 0; k < 5000; k++) begin
      start = 1'b0;
      if (inject && !inj && lut_index == 10'd4 &&
          spi_sclk && !spi_csn) begin
        start = 1'b1;
        inj   = 1'b1;
      end
      if (busy) busy_cyc++;
      if (config_done) begin
        seen = 1'b1;
        break;
      end
      pb = busy;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_busy_prev"}, 32'(pb), 32'd1);
    check({tag, "_cycles"}, 32'(busy_cyc), 32'(exp_cycles));
    check({tag, "_last_idx"}, 32'(lut_index), 32'(exp_last));
    check({tag, "_nframes"}, 32'(frames.size()),
          32'(exp_frames.size()));
    for (int i = 0; i < exp_frames.size() && i < frames.size(); i++) begin
      check($sformatf("%s_frame%0d", tag, i),
            32'(frames[i]), 32'(exp_frames[i]));
      check($sformatf("%s_edges%0d", tag, i),
            32'(edges[i]), 32'd16);
    end
    if (inject) check({tag, "_injected"}, 32'(inj), 32'd1);
    last_frames = frames;
    frames.delete();
    edges.delete();
  endtask

  initial begin
    bit found;
    fill_table();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(spi_csn), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_sdio", 32'(spi_sdio), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(config_done), 32'd0);
    check("rst_idx", 32'(lut_index), 32'd0);

    // Automatic run after reset release.
    rst = 1'b0;
    @(negedge clk);
    check("auto_busy", 32'(busy), 32'd1);
    run_and_check("run1", 1'b0);
    check("entry2", 32'(last_frames[2]), 32'h0C02);
    check("entry9", 32'(last_frames[9]), 32'h055A);

    // Rerun from DONE with a fresh table.
    fill_table();
    pulse_start();
    run_and_check("rerun", 1'b0);

    // Start during SHIFT of entry 4 must not disturb the run.
    fill_table();
    pulse_start();
    run_and_check("ignore", 1'b1);

    // Sentinel at entry 3.
    fill_table();
    lut[3] = 24'hFFFFFF;
    pulse_start();
    run_and_check("sentinel", 1'b0);
    check("sentinel_n3", 32'(last_frames.size()), 32'd3);

    // Reset in the middle of entry 5.
    fill_table();
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (lut_index == 10'd5 && !spi_csn && cur_edges == 7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_bit7", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_csn", 32'(spi_csn), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_idx", 32'(lut_index), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet_sclk", 32'(spi_sclk), 32'd0);
      check("abort_quiet_csn", 32'(spi_csn), 32'd1);
    end
    frames.delete();
    edges.delete();
    rst = 1'b0;
    @(negedge clk);
    check("restart_idx", 32'(lut_index), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    run_and_check("restart", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9781_spi_config.md
AD9781_SPI_CONFIG -- requirements
Module: ad9781_spi_config

Interface
REQ-001 SHALL have parameter LUT_SIZE, default 10: number of table entries written per configuration run (indices 0..LUT_SIZE-1).
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; minimum legal value 2.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to run the configuration sequence, e.g. after a delay_value change.
REQ-006 SHALL have port lut_index, output, 10: address to the configuration look-up table.
REQ-007 SHALL have port lut_data, input, 24: {register address[15:0], register data[7:0]} returned combinationally for lut_index.
REQ-008 SHALL have port spi_csn, output, 1: DAC chip select, active low.
REQ-009 SHALL have port spi_sclk, output, 1: DAC serial clock, idle low.
REQ-010 SHALL have port spi_sdio, output, 1: DAC serial data, MSB first.
REQ-011 SHALL have port busy, output, 1: high while a run is in progress.
REQ-012 SHALL have port config_done, output, 1: high once a run has completed; held until the next run starts or reset.

Function
REQ-013 SHALL implement states IDLE, LOAD, CS_SETUP, SHIFT, CS_HOLD, GAP and DONE.
REQ-014 SHALL start a run automatically on the first cycle after rst deasserts, without needing start.
REQ-015 SHALL also start a run on start=1 when in IDLE or DONE; start in any other state SHALL be ignored.
REQ-016 On run start, SHALL set lut_index=0, busy=1 and config_done=0, then enter LOAD.
REQ-017 LOAD (1 cycle) SHALL capture frame = {1'b0 (write), 2'b00 (1 byte), lut_data[20:16], lut_data[7:0]} into a 16-bit shift register.
REQ-018 In LOAD, if lut_data==24'hFFFFFF, SHALL treat it as a sentinel: skip the frame and end the run (go to DONE).
REQ-019 CS_SETUP SHALL last CLK_DIV cycles, with spi_csn=0, spi_sclk=0 and spi_sdio=frame[15].
REQ-020 SHALL send 16 bits in SHIFT, each bit lasting 2*CLK_DIV cycles: spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 spi_sdio SHALL change only on the cycle spi_sclk goes low, so it is stable across each rising edge (the DAC samples on the rising edge).
REQ-022 CS_HOLD SHALL last CLK_DIV cycles, with spi_sclk=0 and spi_csn=0.
REQ-023 GAP SHALL last 2*CLK_DIV cycles with spi_csn=1.
REQ-024 After GAP: if lut_index==LUT_SIZE-1, SHALL go to DONE; otherwise SHALL increment lut_index and return to LOAD.
REQ-025 On entering DONE, SHALL set busy=0 and config_done=1; lut_index SHALL hold its last value.
REQ-026 Per-entry duration SHALL be 1 + CLK_DIV + 32*CLK_DIV + CLK_DIV + 2*CLK_DIV cycles, i.e. 73 cycles at CLK_DIV=2.
REQ-027 At most one shift/count event per cycle; the bit counter SHALL be 4 bits wide and SHALL not wrap within a frame.

Reset
REQ-028 On rst=1, SHALL on the next clk edge force: state=IDLE, spi_csn=1, spi_sclk=0, spi_sdio=0, lut_index=0, busy=0, config_done=0.
REQ-029 rst asserted mid-frame SHALL abort the frame: spi_csn goes high on that edge, and no further SCLK edges occur.
REQ-030 After rst deasserts, SHALL follow REQ-014 and restart the run from index 0.

Verification
REQ-031 Reset release, CLK_DIV=2, LUT_SIZE=10, table per bench model -> ten CSN-low frames; config_done rises 730 cycles after the run starts; busy falls on the same cycle.
REQ-032 Entry 2 = {16'h0C00, 8'h02} -> SDIO sampled on rising SCLK reads 0x0C02; there are exactly 16 rising edges while CSN is low.
REQ-033 Entry 9 = {16'h0500, 8'h5A} (delay_value=0x5A) -> last frame reads 0x055A; pulsing start in DONE -> full rerun, config_done=0 in the cycle after start.
REQ-034 start pulsed during SHIFT of entry 4 -> ignored; frame count and timing identical to REQ-031.
REQ-035 Entry 3 returns 24'hFFFFFF -> exactly three frames sent, DONE reached with lut_index=3.
REQ-036 rst pulsed at bit 7 of entry 5 -> CSN high the next cycle, no SCLK toggling; the run restarts at index 0 after release.
